// File: rtl/adder_pkg.sv
// adder_pkg: shared helpers for the carry-pipelined adder.
// Provides the chunk-width calculation and the configuration legality check
// used at elaboration time by pipelined_adder.
package adder_pkg;

  // Width of one pipeline chunk; guarded against a zero stage count so the
  // legality check below can report the problem instead of a divide fault.
  function automatic int chunk_w(input int width, input int stages);
    if (stages > 32'sd0) begin
      return width / stages;
    end else begin
      return 32'sd0;
    end
  endfunction

  // A configuration is legal when there is at least one bit, at least one
  // stage, and the bits divide evenly into the stages.
  function automatic bit split_ok(input int width, input int stages);
    if ((width >= 32'sd1) && (stages >= 32'sd1)) begin
      return ((width % stages) == 32'sd0);
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational W-bit ripple-carry adder built from full_adder
// cells. One instance resolves one chunk of the pipelined adder.
// Each bit keeps its own carry nets inside its generate scope so the ripple
// chain is a set of distinct signals rather than one self-referencing vector.
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic w_ci;
    logic w_co;

    if (i == 0) begin : g_first
      assign w_ci = i_cin;
    end else begin : g_rest
      assign w_ci = g_bit[i-1].w_co;
    end

    full_adder u_fa (
      .i_a    (i_a[i]),
      .i_b    (i_b[i]),
      .i_cin  (w_ci),
      .o_s    (o_sum[i]),
      .o_cout (w_co)
    );
  end

  assign o_cout = g_bit[W-1].w_co;

endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell, the basic building block of the
// ripple chunks inside the pipelined adder.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES equal chunks. Stage s
// adds chunk s of the operands plus the carry registered by stage s-1, and
// forwards the finished low sum bits together with the still-unused high
// operand bits. The final stage register drives S/Cout/out_valid directly,
// so there is no combinational path from A/B to S.
//
// Flow control: the whole pipe advances together whenever the output slot is
// empty or being consumed (adv = !out_valid || out_ready); in_ready is adv.
// While stalled every stage holds, so no operation is dropped or duplicated.
//
// Optional feature: define PIPELINED_ADDER_OVF_EN to add a registered
// signed-overflow output Ovf, derived from the operand MSBs that travel
// through the skew registers and the final sum MSB.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             Ovf,
`endif
  output logic             Cout
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (!split_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be >= 1 and an exact multiple of STAGES >= 1");
  end

  // One pipeline slot. sum_lo holds the bits already resolved (upper bits
  // are still zero); a_hi/b_hi carry the operands forward so later stages
  // can pick up their own chunk.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
  } stage_t;

  stage_t r_stage [STAGES];
  logic   w_adv;
  logic   w_unused;

`ifdef PIPELINED_ADDER_OVF_EN
  logic   r_ovf;
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    stage_t           w_src;
    stage_t           w_nx;
    logic [CHUNK-1:0] w_sum;
    logic             w_co;

    if (s == 0) begin : g_head
      // Stage 0 takes its operands and incoming carry straight from the ports.
      always_comb begin
        w_src       = '0;
        w_src.valid = in_valid;
        w_src.carry = Cin;
        w_src.a_hi  = A;
        w_src.b_hi  = B;
      end
    end else begin : g_body
      assign w_src = r_stage[s-1];
    end

    adder_chunk #(
      .W (CHUNK)
    ) u_chunk (
      .i_a    (w_src.a_hi[s*CHUNK +: CHUNK]),
      .i_b    (w_src.b_hi[s*CHUNK +: CHUNK]),
      .i_cin  (w_src.carry),
      .o_sum  (w_sum),
      .o_cout (w_co)
    );

    // Splice this stage's chunk sum and carry in; everything else passes on.
    always_comb begin
      w_nx                          = w_src;
      w_nx.carry                    = w_co;
      w_nx.sum_lo[s*CHUNK +: CHUNK] = w_sum;
    end

    // Stage register: clear on reset, shift on advance, otherwise hold.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_stage[s] <= '0;
      end else if (w_adv) begin
        r_stage[s] <= w_nx;
      end else begin
        r_stage[s] <= r_stage[s];
      end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    if (s == LAST) begin : g_tail
      // Overflow flag registered alongside the final sum; same hold/reset rules.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= (w_nx.a_hi[WIDTH-1] == w_nx.b_hi[WIDTH-1]) &&
                   (w_nx.sum_lo[WIDTH-1] != w_nx.a_hi[WIDTH-1]);
        end else begin
          r_ovf <= r_ovf;
        end
      end
    end
`endif
  end

  assign w_adv     = ~r_stage[LAST].valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_stage[LAST].valid;
  assign S         = r_stage[LAST].sum_lo;
  assign Cout      = r_stage[LAST].carry;

  // The last slot has no chunk left to add, so its operand copies are dead.
  assign w_unused  = ^{r_stage[LAST].a_hi, r_stage[LAST].b_hi};

`ifdef PIPELINED_ADDER_OVF_EN
  assign Ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: self-checking bench for pipelined_adder.
// DUT0 is the default 16-bit / 4-stage build, DUT1 an 8-bit / 1-stage build.
// Directed table vectors cover latency, back-to-back streaming, backpressure
// and mid-flight reset; random traffic on both DUTs is scored against a
// queue model computing A+B+Cin with plain arithmetic.
module tb_pipelined_adder;

  localparam int W  = 16;
  localparam int ST = 4;
  localparam int W1 = 8;
  localparam int NV = 8;

  logic clk = 1'b0;
  logic reset;

  logic          in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [W-1:0]  a, b, s;
  logic          in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1;
  logic [W1-1:0] a1, b1, s1;
`ifdef PIPELINED_ADDER_OVF_EN
  logic          ovf, ovf1;
`endif

  pipelined_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .S(s),
`ifdef PIPELINED_ADDER_OVF_EN
    .Ovf(ovf),
`endif
    .Cout(cout)
  );

  pipelined_adder #(.WIDTH(W1), .STAGES(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a1), .B(b1), .Cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .S(s1),
`ifdef PIPELINED_ADDER_OVF_EN
    .Ovf(ovf1),
`endif
    .Cout(cout1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [17:0] q0 [$];
  logic [8:0]  q1 [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int          got;
    logic        acc0, con0, acc1, con1;
    logic [16:0] sum0;
    logic [8:0]  sum1;
    logic        ov0;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};

    reset = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;

    // Reset state, sampled while reset is still asserted.
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_s", s, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid1", out_valid1, 1'b0);
`ifdef PIPELINED_ADDER_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Single op: carry ripples across all chunks, result after edge N+3.
    drive(vecs[0]);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < ST; k++) begin
      chk("lat_valid", out_valid, (k == ST - 1));
      if (k < ST - 1) tick();
    end
    chk("lat_s", s, vecs[0].s);
    chk("lat_cout", cout, vecs[0].co);
    tick();
    chk("lat_drain", out_valid, 1'b0);

    // Back-to-back streaming of the whole table with out_ready held high.
    got = 0;
    for (int cyc = 0; cyc < NV + ST + 2; cyc++) begin
      if (cyc < NV) drive(vecs[cyc]);
      else in_valid = 1'b0;
      tick();
      if (out_valid) begin
        if (got < NV) begin
          chk("b2b_s", s, vecs[got].s);
          chk("b2b_cout", cout, vecs[got].co);
          chk("b2b_cycle", cyc, got + ST - 1);
`ifdef PIPELINED_ADDER_OVF_EN
          chk("b2b_ovf", ovf, vecs[got].ov);
`endif
        end
        got++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", got, NV);

    // Backpressure: fill, stall 5 cycles with junk offered, then release.
    for (int i = 0; i < ST; i++) begin
      drive(vecs[i]);
      tick();
    end
    in_valid = 1'b1; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      tick();
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_s", s, vecs[0].s);
      chk("bp_hold_cout", cout, vecs[0].co);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    got = 1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      if (out_valid) begin
        if (got < ST) begin
          chk("bp_s", s, vecs[got].s);
          chk("bp_cout", cout, vecs[got].co);
        end
        got++;
      end
    end
    chk("bp_count", got, ST);

    // Reset mid-flight discards everything in the pipe.
    drive(vecs[1]);
    tick();
    drive(vecs[2]);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_s", s, 16'h0000);
    chk("mrst_cout", cout, 1'b0);
    chk("mrst_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mrst_quiet", out_valid, 1'b0);
    end

    // Random traffic on both DUTs against the queue model, then drain.
    for (int cyc = 0; cyc < 1012; cyc++) begin
      if (cyc < 1000) begin
        in_valid   = ($urandom_range(99, 0) < 70);
        out_ready  = ($urandom_range(99, 0) < 70);
        a          = 16'($urandom);
        b          = 16'($urandom);
        cin        = 1'($urandom);
        in_valid1  = ($urandom_range(99, 0) < 60);
        out_ready1 = ($urandom_range(99, 0) < 60);
        a1         = 8'($urandom);
        b1         = 8'($urandom);
        cin1       = 1'($urandom);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; out_ready1 = 1'b1;
      end
      #1;
      acc0 = in_valid && in_ready;
      con0 = out_valid && out_ready;
      acc1 = in_valid1 && in_ready1;
      con1 = out_valid1 && out_ready1;
      if (con0) begin
        chk("rnd0_nonempty", (q0.size() != 0), 1'b1);
        if (q0.size() != 0) begin
          logic [17:0] e;
          e = q0.pop_front();
          chk("rnd0_sum", {cout, s}, e[16:0]);
`ifdef PIPELINED_ADDER_OVF_EN
          chk("rnd0_ovf", ovf, e[17]);
`endif
        end
      end
      if (acc0) begin
        sum0 = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
        ov0  = (a[W-1] == b[W-1]) && (sum0[W-1] != a[W-1]);
        q0.push_back({ov0, sum0});
      end
      if (con1) begin
        chk("rnd1_nonempty", (q1.size() != 0), 1'b1);
        if (q1.size() != 0) chk("rnd1_sum", {cout1, s1}, q1.pop_front());
      end
      if (acc1) begin
        sum1 = {1'b0, a1} + {1'b0, b1} + {8'h00, cin1};
        q1.push_back(sum1);
      end
      @(posedge clk);
      #1;
      // A single-stage adder holds exactly the accepted, unconsumed op.
      chk("rnd1_occupancy", out_valid1, (q1.size() != 0));
    end
    chk("rnd0_drain", q0.size(), 0);
    chk("rnd1_drain", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
